// File: rtl/child_collector_pkg.sv
// child_collector_pkg: default widths, FIFO entry type and round-robin picker shared by the collector
package child_collector_pkg;
  localparam int CC_CHILDREN = 5;
  localparam int CC_DATA_W = 16;
  localparam int CC_ID_W = $clog2(CC_CHILDREN);
  localparam int MAX_CHILDREN = 16;
  typedef struct packed {
    logic [CC_ID_W-1:0] id;
    logic [CC_DATA_W-1:0] data;
  } collector_entry_t;
  typedef struct packed {
    logic found;
    logic [3:0] idx;
  } rr_pick_t;
  function automatic rr_pick_t rr_pick(input logic [MAX_CHILDREN-1:0] valid, input logic [3:0] ptr, input int n = CC_CHILDREN);
    rr_pick_t p;
    int j;
    p = '0;
    for (int k = 0; k < MAX_CHILDREN; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !p.found && valid[4'(j)]) begin
        p.found = 1'b1;
        p.idx = 4'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/collector_fifo.sv
// collector_fifo: sync FIFO of collector entries; ports clk, rst(async), push, pop, din, dout(head), count
module collector_fifo
  import child_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = collector_entry_t,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  entry_t        din,
  output entry_t        dout,
  output logic [CW-1:0] count
);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign wr = push && count != CW'(DEPTH);
  assign rd = pop && count != '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/child_token_collector.sv
// child_token_collector: round-robin merge of child valid/ready channels into a tagged FIFO stream; ports clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_id, fifo_count (+grant_cnt with CHILD_TOKEN_COLLECTOR_STATS_EN)
module child_token_collector
  import child_collector_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W = $clog2(NUM_CHILDREN),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CHILDREN-1:0]    in_valid,
  output logic [NUM_CHILDREN-1:0]    in_ready,
  input  logic [NUM_CHILDREN*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ID_W-1:0]            out_id,
  output logic [CW-1:0]              fifo_count
`ifdef CHILD_TOKEN_COLLECTOR_STATS_EN
  ,
  output logic [NUM_CHILDREN*16-1:0] grant_cnt
`endif
);
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DATA_W-1:0] data;
  } entry_t;
  logic [ID_W-1:0] rr_ptr;
  rr_pick_t pk;
  logic push, pop;
  entry_t din, head;
  always_comb begin
    pk = rr_pick(MAX_CHILDREN'(in_valid), 4'(rr_ptr), NUM_CHILDREN);
    push = !rst && fifo_count < CW'(FIFO_DEPTH) && pk.found;
    in_ready = push ? NUM_CHILDREN'(1) << pk.idx : '0;
    din = '{id: ID_W'(pk.idx), data: in_data[pk.idx*DATA_W +: DATA_W]};
  end
  assign out_valid = fifo_count != '0;
  assign pop = out_valid && out_ready;
  assign out_data = head.data;
  assign out_id = head.id;
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= '0;
    else if (push) rr_ptr <= (pk.idx == 4'(NUM_CHILDREN - 1)) ? '0 : ID_W'(pk.idx + 4'd1);
`ifdef CHILD_TOKEN_COLLECTOR_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) grant_cnt <= '0;
    else if (push) grant_cnt[pk.idx*16 +: 16] <= grant_cnt[pk.idx*16 +: 16] + 16'd1;
`endif
  collector_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(head),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_child_token_collector.sv
// tb_child_token_collector: directed and random checks of the collector against a queue-based model
module tb_child_token_collector;
  localparam int N = 5, DW = 16, D = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] in_valid = '0, in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [2:0] out_id, fifo_count;
`ifdef CHILD_TOKEN_COLLECTOR_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif
  child_token_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .fifo_count(fifo_count)
`ifdef CHILD_TOKEN_COLLECTOR_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int id; int data;} tok_t;
  tok_t q[$];
  int ptr, nvec, nbad, exp_ready, exp_idx;
  int cnt[N];
  bit exp_push, exp_pop;
  function automatic void chk(string name, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction
  function automatic void model_eval();
    bit found = 0;
    exp_idx = 0;
    for (int k = 0; k < N; k++)
      if (!found && in_valid[(ptr + k) % N]) begin
        found = 1;
        exp_idx = (ptr + k) % N;
      end
    exp_push = found && q.size() < D;
    exp_ready = exp_push ? (1 << exp_idx) : 0;
    exp_pop = q.size() > 0 && out_ready;
  endfunction
  task automatic settle();
    #2;
    model_eval();
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, q.size() != 0);
    chk("fifo_count", fifo_count, q.size());
    if (q.size() != 0) begin
      chk("out_id", out_id, q[0].id);
      chk("out_data", out_data, q[0].data);
    end
`ifdef CHILD_TOKEN_COLLECTOR_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], cnt[i]);
`endif
  endtask
  task automatic edge_();
    @(posedge clk);
    if (exp_pop) void'(q.pop_front());
    if (exp_push) begin
      q.push_back('{exp_idx, int'(in_data[exp_idx*DW +: DW])});
      ptr = (exp_idx + 1) % N;
      cnt[exp_idx] = (cnt[exp_idx] + 1) & 16'hFFFF;
    end
    #1;
  endtask
  task automatic model_clear();
    q.delete();
    ptr = 0;
    foreach (cnt[i]) cnt[i] = 0;
    exp_push = 0;
    exp_pop = 0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = '1;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = '0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 16'(16'h0100 + i);
    do_reset();
    in_valid = 5'b00100;
    in_data[2*DW +: DW] = 16'h00AA;
    settle();
    chk("single_ready", in_ready, 5'b00100);
    edge_();
    in_valid = '0;
    settle();
    chk("single_valid", out_valid, 1);
    chk("single_id", out_id, 2);
    chk("single_data", out_data, 16'h00AA);
    do_reset();
    in_valid = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      settle();
      if (c > 0) chk("fair_id", out_id, (c - 1) % 5);
      edge_();
    end
    do_reset();
    in_valid = '1;
    for (int c = 0; c < 4; c++) begin
      settle();
      edge_();
    end
    settle();
    chk("full_count", fifo_count, 4);
    chk("full_ready", in_ready, 0);
    chk("full_head", out_id, 0);
    out_ready = 1'b1;
    settle();
    chk("full_pop_ready", in_ready, 0);
    edge_();
    in_valid = '0;
    settle();
    chk("after_pop_count", fifo_count, 3);
    do_reset();
    out_ready = 1'b1;
    in_valid = 5'b01000;
    settle();
    edge_();
    in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      settle();
      edge_();
    end
    in_valid = 5'b10001;
    settle();
    chk("hold_ptr", in_ready, 5'b10000);
    edge_();
    do_reset();
    in_valid = '1;
    for (int c = 0; c < 3; c++) begin
      settle();
      edge_();
    end
    #2 rst = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_count", fifo_count, 0);
    chk("async_ready", in_ready, 0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 5'b00001;
    in_data[0 +: DW] = 16'h1234;
    settle();
    edge_();
    in_valid = '0;
    settle();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_id", out_id, 0);
    chk("post_rst_data", out_data, 16'h1234);
`ifdef CHILD_TOKEN_COLLECTOR_STATS_EN
    do_reset();
    out_ready = 1'b1;
    in_valid = 5'b00010;
    for (int c = 0; c < 7; c++) begin
      settle();
      edge_();
    end
    in_valid = 5'b10000;
    for (int c = 0; c < 2; c++) begin
      settle();
      edge_();
    end
    in_valid = '0;
    settle();
    chk("stats_c1", grant_cnt[16 +: 16], 7);
    chk("stats_c4", grant_cnt[64 +: 16], 2);
    chk("stats_c0", grant_cnt[0 +: 16], 0);
`endif
    do_reset();
    for (int c = 0; c < 400; c++) begin
      settle();
      edge_();
      for (int i = 0; i < N; i++)
        if (!in_valid[i] || (exp_push && exp_idx == i)) begin
          in_valid[i] = ($urandom % 3) == 0;
          in_data[i*DW +: DW] = 16'($urandom);
        end
      out_ready = ($urandom % 4) != 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
